// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the piso_shift8 serial transmitter:
//   - FSM state encoding (ST_IDLE / ST_SHIFT / ST_DONE)
//   - data and counter widths
//   - terminal counts for the plain (8-bit) and parity (9-bit) frames
// Optional feature macro: PISO_PARITY_EN (selects the 9-bit parity frame).
// -----------------------------------------------------------------------------
package piso_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  // Counter value while the last frame bit is on the wire.
  localparam logic [CNT_W-1:0] TC_PLAIN  = 4'd7;
  localparam logic [CNT_W-1:0] TC_PARITY = 4'd8;

`ifdef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] TC_FRAME = TC_PARITY;
`else
  localparam logic [CNT_W-1:0] TC_FRAME = TC_PLAIN;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

`ifdef PISO_PARITY_EN
  // Even parity: the appended bit makes the 9-bit frame's ones-count even.
  function automatic logic even_parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction
`endif

endpackage

// File: rtl/shift_cnt4.sv
// -----------------------------------------------------------------------------
// shift_cnt4
// 4-bit up counter that tracks the bit position within a frame.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (count -> 0)
//   clr  - synchronous clear (has priority over en)
//   en   - count enable
//   tc   - high while the count equals the TC parameter
// -----------------------------------------------------------------------------
module shift_cnt4
  import piso_pkg::*;
#(
  parameter logic [CNT_W-1:0] TC = TC_PLAIN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of the order of statements or processes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == TC);

endmodule

// File: rtl/piso_shift8.sv
// -----------------------------------------------------------------------------
// piso_shift8
// 8-bit parallel-in / serial-out transmitter. A byte is captured when start
// is seen in IDLE, shifted out one bit per clock with so_valid high, and the
// frame ends with a one-cycle done pulse before returning to IDLE.
// Parameters:
//   LSB_FIRST - 0: d[7] first (register order), 1: d[0] first
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset; aborts any frame silently
//   start    - load request, only honoured in IDLE
//   d        - parallel byte, captured on the accepting edge
//   so       - serial data (0 outside SHIFT)
//   so_valid - so carries a frame bit
//   busy     - frame in progress (SHIFT or DONE)
//   done     - one-cycle pulse after the last bit
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit, making
// the frame 9 bits long.
// All outputs decode only flops; nothing from the inputs reaches them
// combinationally.
// -----------------------------------------------------------------------------
module piso_shift8
  import piso_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] d,
  output logic              so,
  output logic              so_valid,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic              load;
  logic              shift_en;
  logic              last;
  logic              data_bit;

  // ---------------------------------------------------------------------------
  // Bit-position counter; last is high while the final frame bit is driven.
  // ---------------------------------------------------------------------------
  shift_cnt4 #(
    .TC (TC_FRAME)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (shift_en),
    .tc  (last)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register: the outgoing bit always sits at the end selected by
  // LSB_FIRST, and zeros fill in from the other end.
  // ---------------------------------------------------------------------------
  // NOTE: the shift register is cleared by reset so a partial frame can never
  // leak into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= d;
    end else if (shift_en) begin
      if (LSB_FIRST) begin
        sreg <= {1'b0, sreg[DATA_W-1:1]};
      end else begin
        sreg <= {sreg[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign data_bit = LSB_FIRST ? sreg[0] : sreg[DATA_W-1];

`ifdef PISO_PARITY_EN
  // Parity is computed from the byte as captured, so later changes on d
  // cannot affect it; it goes out in the ninth SHIFT cycle.
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= even_parity(d);
    end
  end

  assign so = (state == ST_SHIFT) & (last ? par_q : data_bit);
`else
  assign so = (state == ST_SHIFT) & data_bit;
`endif

  assign so_valid = (state == ST_SHIFT);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_piso_shift8.sv
// -----------------------------------------------------------------------------
// tb_piso_shift8
// Drives an MSB-first and an LSB-first piso_shift8 from the same stimulus.
// Expected serial bits are queued when a byte is launched and popped as each
// instance raises so_valid; frame timing, handshake and reset behaviour are
// checked at directed points. Honours PISO_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_piso_shift8;

`ifdef PISO_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif
  localparam int PERIOD = FRAME_BITS + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] d;

  logic so_m, sv_m, busy_m, done_m;
  logic so_l, sv_l, busy_l, done_l;

  int n_cmp = 0;
  int n_bad = 0;
  int done_m_n = 0;
  int done_l_n = 0;

  logic q_m[$];
  logic q_l[$];

  always #5 clk = ~clk;

  piso_shift8 #(.LSB_FIRST(1'b0)) u_msb (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .d        (d),
    .so       (so_m),
    .so_valid (sv_m),
    .busy     (busy_m),
    .done     (done_m)
  );

  piso_shift8 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .d        (d),
    .so       (so_l),
    .so_valid (sv_l),
    .busy     (busy_l),
    .done     (done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      q_m.push_back(v[7-i]);
      q_l.push_back(v[i]);
    end
`ifdef PISO_PARITY_EN
    q_m.push_back(^v);
    q_l.push_back(^v);
`endif
  endfunction

  // Scoreboard monitor: each valid bit must match the head of the queue;
  // outside valid cycles so must be 0.
  always @(negedge clk) begin
    logic e;
    if (sv_m) begin
      if (q_m.size() == 0) begin
        check("sb_msb_unexpected_valid", 32'(sv_m), 32'd0);
      end else begin
        e = q_m.pop_front();
        check("sb_msb_bit", 32'(so_m), 32'(e));
      end
    end else if (!rst) begin
      check("msb_so_idle", 32'(so_m), 32'd0);
    end
    if (sv_l) begin
      if (q_l.size() == 0) begin
        check("sb_lsb_unexpected_valid", 32'(sv_l), 32'd0);
      end else begin
        e = q_l.pop_front();
        check("sb_lsb_bit", 32'(so_l), 32'(e));
      end
    end else if (!rst) begin
      check("lsb_so_idle", 32'(so_l), 32'd0);
    end
    if (done_m) done_m_n++;
    if (done_l) done_l_n++;
  end

  // Present a byte with start for one accepting edge; returns at the negedge
  // of the first SHIFT cycle (k=1) with d scrambled to prove it was captured.
  task automatic launch(input logic [7:0] v);
    d     = v;
    start = 1'b1;
    push_frame(v);
    @(negedge clk);
    start = 1'b0;
    d     = ~v;
  endtask

  // Called at the negedge of cycle k0 after the accepting edge. Expects done
  // in cycle FRAME_BITS+1, busy up to and including it, then IDLE.
  task automatic measure(input string tag, input int k0);
    int k       = k0;
    int busy_n  = 0;
    int done_at = 0;
    while (k <= FRAME_BITS + 6) begin
      if (busy_m) busy_n++;
      if (done_m) begin
        done_at = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'(FRAME_BITS + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(FRAME_BITS + 2 - k0));
    check({tag, "_lsb_done_sync"}, 32'(done_l), 32'(done_m));
    check({tag, "_msb_queue_drained"}, 32'(q_m.size()), 32'd0);
    check({tag, "_lsb_queue_drained"}, 32'(q_l.size()), 32'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, 32'({busy_m, done_m, busy_l, done_l}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dm0;
    int dl0;

    rst   = 1'b1;
    start = 1'b0;
    d     = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({so_m, sv_m, busy_m, done_m, so_l, sv_l, busy_l, done_l}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame, both bit orders
    launch(8'hA5);
    measure("a5", 1);

    // start re-asserted mid-SHIFT with d=FF is ignored
    dm0 = done_m_n;
    dl0 = done_l_n;
    launch(8'h96);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    d     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    measure("ignore_start", 4);
    check("ignore_start_msb_one_done", 32'(done_m_n - dm0), 32'd1);
    check("ignore_start_lsb_one_done", 32'(done_l_n - dl0), 32'd1);

    // start held high: three back-to-back frames, one every PERIOD cycles
    d     = 8'h3C;
    start = 1'b1;
    push_frame(8'h3C);
    @(negedge clk);
    for (int k = 1; k <= 3 * PERIOD; k++) begin
      check("cont_msb_valid", 32'(sv_m), 32'(((k - 1) % PERIOD) < FRAME_BITS));
      check("cont_lsb_valid", 32'(sv_l), 32'(((k - 1) % PERIOD) < FRAME_BITS));
      check("cont_done", 32'(done_m), 32'((k % PERIOD) == FRAME_BITS + 1));
      if (k == PERIOD || k == 2 * PERIOD) push_frame(8'h3C);
      if (k == 3 * PERIOD) start = 1'b0;
      @(negedge clk);
    end
    check("cont_idle_after", 32'({busy_m, busy_l}), 32'd0);
    check("cont_msb_queue_drained", 32'(q_m.size()), 32'd0);
    check("cont_lsb_queue_drained", 32'(q_l.size()), 32'd0);

    // Reset mid-SHIFT after bit 3: outputs drop without a clock edge
    launch(8'hC3);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs",
          32'({so_m, sv_m, busy_m, done_m, so_l, sv_l, busy_l, done_l}), 32'd0);
    q_m.delete();
    q_l.delete();
    dm0 = done_m_n;
    dl0 = done_l_n;
    // start held through reset release is taken on the first free edge
    d     = 8'h55;
    start = 1'b1;
    push_frame(8'h55);
    @(negedge clk);
    @(negedge clk);
    check("reset_no_done_msb", 32'(done_m_n), 32'(dm0));
    check("reset_no_done_lsb", 32'(done_l_n), 32'(dl0));
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    d     = 8'hAA;
    measure("post_reset_55", 1);

    // Odd and even ones-count bytes (parity bit 1 and 0 when enabled)
    launch(8'h07);
    measure("x07", 1);
    launch(8'h03);
    measure("x03", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_shift8.md
# piso_shift8

8-bit parallel-in, serial-out shift transmitter. It is the read-out end of the 8-bit D flip-flop register: it loads a byte in one cycle, then shifts it out one bit per clock with a valid strobe and start/busy/done handshake. It sits between a parallel byte source and a single-wire serial consumer, which re-assembles the byte with a serial-in register.

## Interface
Parameters:
- `LSB_FIRST`, default 0: 0 shifts bit 7 first, matching register bit order; 1 shifts bit 0 first.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst`  input  1  — reset, asynchronous and active-high.
- `start`  input  1  — load request; sampled only in IDLE.
- `d`  input  8  — parallel byte; captured on the edge where `start` is accepted.
- `so`  output  1  — serial data bit.
- `so_valid`  output  1  — `so` carries a frame bit this cycle.
- `busy`  output  1  — frame in progress (SHIFT or DONE).
- `done`  output  1  — one-cycle pulse after the last bit.

## Operation
- FSM states:
  - IDLE: `busy`=0. If `start`=1, load `d` into the shift register, clear the bit counter, and go to SHIFT.
  - SHIFT: drive the current bit on `so` with `so_valid`=1, shift by one, and increment the counter. After the last bit, go to DONE.
  - DONE: `done`=1 and `so_valid`=0 for one cycle, then return to IDLE.
- Bit order:
  - `LSB_FIRST`=0: `d[7]`, then `d[6]`, … `d[0]`.
  - `LSB_FIRST`=1: the reverse order.
- `start` is ignored in SHIFT and DONE; there is no queuing. Back-to-back frames need `start` in IDLE, so the minimum frame period is 10 cycles (11 with parity).
- Changes on `d` after capture have no effect on the frame in flight.
- Outputs outside SHIFT: `so`=0 and `so_valid`=0.
- Bit counter is 4 bits wide. The terminal count is 7, or 8 with parity. The counter never wraps within a frame and is cleared on load.
- Reset at any time, including mid-frame:
  - forces IDLE asynchronously;
  - clears the shift register and counter;
  - drives all outputs to 0 (`so`, `so_valid`, `busy`, `done`);
  - discards the partial frame; no `done` pulse is issued.
- `start` held high through reset release is accepted on the first rising edge with `rst`=0.

## Timing
- `start`=1 in IDLE is sampled at edge N:
  - `busy` rises after edge N.
  - First bit is valid in the cycle after edge N, through edge N+1.
  - Bits occupy the cycles following edges N … N+7.
  - `done`=1 in the cycle after edge N+8.
  - IDLE (`busy`=0) after edge N+9.
- Latency from accept to first bit: 1 cycle. Latency from accept to `done`: 9 cycles, or 10 with parity.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PISO_PARITY_EN`:
  - Defined: after the 8 data bits, one extra SHIFT cycle drives the even-parity bit (XOR of the captured byte) with `so_valid`=1. The frame is 9 bits and `done` follows it.
  - Undefined: the frame is 8 bits and no parity logic exists.

## Structure
- Shared package `piso_pkg` contains:
  - state encoding constants `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2;
  - `DATA_W`=8 and `CNT_W`=4;
  - the terminal-count constants for the plain and parity frame lengths.
- One sub-module, `shift_cnt4`: a 4-bit counter with asynchronous active-high reset, synchronous clear, enable, and terminal-count flag output. The FSM and the shift register stay in the top level.

## Test plan
- Reset asserted mid-SHIFT after bit 3 → all outputs 0 immediately (asynchronously); no `done`. A new `start` with `d`=8'h55 then yields 0,1,0,1,0,1,0,1.
- `d`=8'hA5, `start` for 1 cycle, `LSB_FIRST`=0 → `so` = 1,0,1,0,0,1,0,1 on 8 consecutive `so_valid` cycles. `done` arrives 1 cycle after the last bit; `busy` is high for 9 cycles.
- `d`=8'hA5, `LSB_FIRST`=1 → `so` = 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 checked against bit-0-first order. Assert the sequence equals `d[0]`..`d[7]`.
- `start` pulsed again during SHIFT with `d`=8'hFF → ignored; the original byte completes unchanged, and exactly one `done` pulse occurs.
- `start` held high continuously with `d`=8'h3C → frames repeat every 10 cycles. `so_valid` is low in the DONE and IDLE cycles between frames.
- With `PISO_PARITY_EN` defined, `d`=8'h07 → 8 data bits then parity bit 1. `done` is 10 cycles after accept. With `d`=8'h03, the parity bit is 0.
